pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the multi-cycle CPU, successor to the single write-enabled PC register. Holds the current PC, computes the next PC from a selectable source (sequential, branch, jump, return), keeps a small return-address stack (RAS) for call/return, and redirects to a fixed exception vector while capturing the faulting PC. It sits between the control FSM/ALU and the instruction-memory address port.

## Interface
- `WIDTH`, 32: PC and address width in bits.
- `RESET_VECTOR`, 0: PC value after reset.
- `EXC_VECTOR`, 32'h0000_0080: PC loaded on exception.
- `STEP`, 4: sequential increment.
- `RAS_DEPTH`, 4: RAS entries, at least 2, power of two.
- `i_clk`, input, 1: clock. Single clock domain.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_pc_w_c`, input, 1: PC write enable from the control FSM.
- `i_sel`, input, 2: next-PC source. 0 = SEQ, 1 = BRANCH, 2 = JUMP, 3 = RET.
- `i_target`, input, WIDTH: branch/jump target, and RET fallback.
- `i_call`, input, 1: with JUMP, or with RET, push PC+STEP onto the RAS.
- `i_exc`, input, 1: exception request.
- `o_pc`, output, WIDTH: current PC (registered).
- `o_epc`, output, WIDTH: PC captured at the last exception (registered).
- `o_ras_empty`, output, 1: RAS holds 0 entries.
- `o_ras_full`, output, 1: RAS holds RAS_DEPTH entries.
- `o_ras_ovf`, output, 1: sticky. Set when a push hit a full RAS; cleared only by reset.
- `o_ras_unf`, output, 1: one-cycle pulse. RET was taken with an empty RAS.
- `o_misalign`, output, 1: one-cycle pulse. A misaligned target trapped (PC_ALIGN_CHK_EN only).

## Operation
Priority per rising edge, highest first:
1. **`i_exc` = 1.** Acts regardless of `i_pc_w_c`.
   - `o_pc` <= EXC_VECTOR.
   - `o_epc` <= `o_pc`.
   - RAS unchanged. `i_sel` and `i_call` ignored.
2. **`i_pc_w_c` = 0.** All state holds. Pulses stay 0.
3. **`i_pc_w_c` = 1:**
   - SEQ: `o_pc` <= `o_pc` + STEP, modulo 2^WIDTH. RAS unchanged.
   - BRANCH: `o_pc` <= `i_target`. RAS unchanged. `i_call` ignored.
   - JUMP: `o_pc` <= `i_target`. If `i_call`, push `o_pc` + STEP.
   - RET, RAS non-empty: `o_pc` <= top entry, then pop.
   - RET, RAS empty: `o_pc` <= `i_target`; `o_ras_unf` pulses; count stays 0.
   - RET with `i_call`: pop and push in the same cycle.
     - Top is replaced by `o_pc` + STEP; count unchanged.
     - On an empty RAS this is a plain push of 1 entry, and `o_ras_unf` still pulses.

RAS behaviour:
- Circular buffer with a top pointer and a count from 0 to RAS_DEPTH.
- Push when full: overwrite the oldest entry, advance the pointer, keep count = RAS_DEPTH, set `o_ras_ovf`.
- Flags are derived combinationally from the registered count.

## Timing
- All state updates on posedge `i_clk`. The new `o_pc` is visible 1 cycle after the enabling edge.
- Next-PC selection is combinational from inputs and current state. No extra latency.
- `o_misalign` and `o_ras_unf` are high for exactly the cycle after the causing edge.
- Reset values:
  - `o_pc` = RESET_VECTOR, `o_epc` = 0.
  - RAS count = 0 and pointer = 0. Entry contents are don't-care and not reset.
  - `o_ras_empty` = 1, `o_ras_full` = 0, `o_ras_ovf` = 0, `o_ras_unf` = 0, `o_misalign` = 0.
- Reset asserted mid-operation clears state immediately, asynchronously. The first update happens on the first edge after deassertion.

## Configuration
- `PC_ALIGN_CHK_EN` defined:
  - Applies when `i_pc_w_c` = 1 and the PC would load `i_target` or a RAS entry with bits [1:0] ≠ 0.
  - The load is treated as an exception: `o_pc` <= EXC_VECTOR, `o_epc` <= `o_pc`, `o_misalign` pulses.
  - The RAS push/pop for that cycle is suppressed.
- Not defined: targets load unmodified. `o_misalign` is tied 0.

## Structure
- Package `pc_pkg`:
  - next-PC select encodings `PC_SEL_SEQ`, `PC_SEL_BRANCH`, `PC_SEL_JUMP`, `PC_SEL_RET`;
  - typedef for the 2-bit select;
  - default EXC_VECTOR constant.
- Sub-module `pc_ras`:
  - parametrised by WIDTH and RAS_DEPTH;
  - push/pop/data ports;
  - outputs empty, full, ovf and the top entry.
- `pc_unit` contains the priority logic, the PC and EPC registers, and the alignment check.

## Test plan
- **Reset and sequential fetch:** reset, then `i_pc_w_c` = 1 with SEQ for 3 cycles -> `o_pc` = 0, 4, 8, 12. Set WIDTH = 8 with PC at 8'hFC, then SEQ -> `o_pc` = 8'h00.
- **Hold:** `i_pc_w_c` = 0 for 5 cycles at PC = 0x40 -> `o_pc` stays 0x40 and RAS count is unchanged.
- **Call/return:** at PC 0x10, JUMP to 0x100 with `i_call` -> `o_pc` = 0x100. Then RET -> `o_pc` = 0x14 and `o_ras_empty` = 1.
- **Overflow and underflow (RAS_DEPTH = 4):**
  - 5 calls from PCs A0..A4 -> `o_ras_ovf` = 1, `o_ras_full` = 1.
  - 4 RETs -> A4+4, A3+4, A2+4, A1+4.
  - 5th RET with `i_target` = 0x200 -> `o_pc` = 0x200 and `o_ras_unf` pulses.
- **Exception priority:** `i_exc` = 1 together with JUMP+call to 0x300 while `i_pc_w_c` = 0, at PC 0x24 -> `o_pc` = EXC_VECTOR, `o_epc` = 0x24, RAS unchanged.
- **Alignment (PC_ALIGN_CHK_EN):** JUMP to 0x102 at PC 0x30 -> `o_pc` = EXC_VECTOR, `o_epc` = 0x30, `o_misalign` pulses 1 cycle. Without the macro -> `o_pc` = 0x102.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select encodings
// and the default exception vector.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEL_SEQ    = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_JUMP   = 2'd2,
        PC_SEL_RET    = 2'd3
    } pc_sel_e;

    localparam logic [31:0] PC_EXC_VECTOR_DFLT = 32'h0000_0080;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and an occupancy
// count; a push on a full stack overwrites the oldest entry and sets sticky ovf.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_ovf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] mem_r [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] ptr_nxt_s;
    logic [PTR_W-1:0] wr_idx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             ovf_r;
    logic             wr_s;
    logic             ovf_set_s;
    logic             empty_s;
    logic             full_s;

    assign empty_s = (cnt_r == {CNT_W{1'b0}});
    assign full_s  = (cnt_r == CNT_MAX);

    // Next pointer/count; pop+push on a non-empty stack rewrites the top in place
    always_comb begin
        ptr_nxt_s = ptr_r;
        cnt_nxt_s = cnt_r;
        wr_idx_s  = ptr_r;
        wr_s      = 1'b0;
        ovf_set_s = 1'b0;
        if (i_push && i_pop && !empty_s) begin
            wr_s     = 1'b1;
            wr_idx_s = ptr_r;
        end else if (i_push) begin
            ptr_nxt_s = ptr_r + PTR_ONE;
            wr_idx_s  = ptr_r + PTR_ONE;
            wr_s      = 1'b1;
            if (full_s) begin
                ovf_set_s = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else if (i_pop && !empty_s) begin
            ptr_nxt_s = ptr_r - PTR_ONE;
            cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Pointer, count and sticky overflow flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_r <= {PTR_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            ovf_r <= 1'b0;
        end else begin
            ptr_r <= ptr_nxt_s;
            cnt_r <= cnt_nxt_s;
            ovf_r <= ovf_r | ovf_set_s;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge i_clk) begin
        if (wr_s) begin
            mem_r[wr_idx_s] <= i_data;
        end
    end

    assign o_top   = mem_r[ptr_r];
    assign o_empty = empty_s;
    assign o_full  = full_s;
    assign o_ovf   = ovf_r;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit with next-PC selection, return-address stack and
// exception redirect. Define PC_ALIGN_CHK_EN to trap misaligned target loads.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR_DFLT),
    parameter int               STEP         = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pc_w_c,
    input  logic [1:0]       i_sel,
    input  logic [WIDTH-1:0] i_target,
    input  logic             i_call,
    input  logic             i_exc,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_epc,
    output logic             o_ras_empty,
    output logic             o_ras_full,
    output logic             o_ras_ovf,
    output logic             o_ras_unf,
    output logic             o_misalign
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    pc_sel_e          sel_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] epc_r;
    logic [WIDTH-1:0] pc_nxt_s;
    logic [WIDTH-1:0] epc_nxt_s;
    logic [WIDTH-1:0] seq_s;
    logic [WIDTH-1:0] ras_top_s;
    logic             ras_empty_s;
    logic             push_s;
    logic             pop_s;
    logic             unf_s;
    logic             unf_r;

    assign sel_s = pc_sel_e'(i_sel);
    assign seq_s = pc_r + STEP_W;

`ifdef PC_ALIGN_CHK_EN
    logic tgt_load_s;
    logic mis_s;
    logic mis_r;
    // Every source except SEQ loads an externally supplied or stacked address
    assign tgt_load_s = (sel_s != PC_SEL_SEQ);
`endif

    // Priority: exception, then hold, then the selected next-PC source
    always_comb begin
        pc_nxt_s  = pc_r;
        epc_nxt_s = epc_r;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        unf_s     = 1'b0;
`ifdef PC_ALIGN_CHK_EN
        mis_s     = 1'b0;
`endif
        if (i_exc) begin
            pc_nxt_s  = EXC_VECTOR;
            epc_nxt_s = pc_r;
        end else if (!i_pc_w_c) begin
            pc_nxt_s = pc_r;
        end else begin
            case (sel_s)
                PC_SEL_SEQ:    pc_nxt_s = seq_s;
                PC_SEL_BRANCH: pc_nxt_s = i_target;
                PC_SEL_JUMP: begin
                    pc_nxt_s = i_target;
                    push_s   = i_call;
                end
                PC_SEL_RET: begin
                    push_s = i_call;
                    if (!ras_empty_s) begin
                        pc_nxt_s = ras_top_s;
                        pop_s    = 1'b1;
                    end else begin
                        pc_nxt_s = i_target;
                        unf_s    = 1'b1;
                    end
                end
                default: pc_nxt_s = pc_r;
            endcase
`ifdef PC_ALIGN_CHK_EN
            // A misaligned load becomes an exception and leaves the RAS untouched
            if (tgt_load_s && (pc_nxt_s[1:0] != 2'b00)) begin
                pc_nxt_s  = EXC_VECTOR;
                epc_nxt_s = pc_r;
                mis_s     = 1'b1;
                push_s    = 1'b0;
                pop_s     = 1'b0;
                unf_s     = 1'b0;
            end else begin
                mis_s = 1'b0;
            end
`endif
        end
    end

    // PC, EPC and the single-cycle status pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_r  <= RESET_VECTOR;
            epc_r <= {WIDTH{1'b0}};
            unf_r <= 1'b0;
        end else begin
            pc_r  <= pc_nxt_s;
            epc_r <= epc_nxt_s;
            unf_r <= unf_s;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    // Misalignment pulse register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mis_r <= 1'b0;
        end else begin
            mis_r <= mis_s;
        end
    end
    assign o_misalign = mis_r;
`else
    assign o_misalign = 1'b0;
`endif

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push_s),
        .i_pop   (pop_s),
        .i_data  (seq_s),
        .o_top   (ras_top_s),
        .o_empty (ras_empty_s),
        .o_full  (o_ras_full),
        .o_ovf   (o_ras_ovf)
    );

    assign o_pc        = pc_r;
    assign o_epc       = epc_r;
    assign o_ras_empty = ras_empty_s;
    assign o_ras_unf   = unf_r;

endmodule

// File: tb/tb_pc_unit.sv
// Table-driven bench for pc_unit: a 32-bit instance walks a directed vector
// table; an 8-bit instance checks sequential wrap-around.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        w;
    logic [1:0]  sel;
    logic [31:0] tgt;
    logic        call;
    logic        exc;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;
    logic        ras_unf;
    logic        misalign;

    logic        w8;
    logic [1:0]  sel8;
    logic [7:0]  tgt8;
    logic        call8;
    logic        exc8;
    logic [7:0]  pc8;
    logic [7:0]  epc8;
    logic        empty8;
    logic        full8;
    logic        ovf8;
    logic        unf8;
    logic        mis8;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        w;
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic        call;
        logic        exc;
        logic [31:0] e_pc;
        logic [31:0] e_epc;
        logic        e_empty;
        logic        e_full;
        logic        e_ovf;
        logic        e_unf;
        logic        e_mis;
    } vec_t;

    vec_t tbl[$];

    localparam logic [1:0] SEQ = 2'd0;
    localparam logic [1:0] BR  = 2'd1;
    localparam logic [1:0] JMP = 2'd2;
    localparam logic [1:0] RET = 2'd3;

    pc_unit u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_pc_w_c    (w),
        .i_sel       (sel),
        .i_target    (tgt),
        .i_call      (call),
        .i_exc       (exc),
        .o_pc        (pc),
        .o_epc       (epc),
        .o_ras_empty (ras_empty),
        .o_ras_full  (ras_full),
        .o_ras_ovf   (ras_ovf),
        .o_ras_unf   (ras_unf),
        .o_misalign  (misalign)
    );

    pc_unit #(.WIDTH(8)) u_dut8 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_pc_w_c    (w8),
        .i_sel       (sel8),
        .i_target    (tgt8),
        .i_call      (call8),
        .i_exc       (exc8),
        .o_pc        (pc8),
        .o_epc       (epc8),
        .o_ras_empty (empty8),
        .o_ras_full  (full8),
        .o_ras_ovf   (ovf8),
        .o_ras_unf   (unf8),
        .o_misalign  (mis8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic vw, input logic [1:0] vsel, input logic [31:0] vtgt,
                                input logic vcall, input logic vexc, input logic [31:0] epc_v,
                                input logic [31:0] eepc_v, input logic em, input logic fu,
                                input logic ov, input logic un, input logic mi);
        vec_t v;
        v.w = vw; v.sel = vsel; v.tgt = vtgt; v.call = vcall; v.exc = vexc;
        v.e_pc = epc_v; v.e_epc = eepc_v; v.e_empty = em; v.e_full = fu;
        v.e_ovf = ov; v.e_unf = un; v.e_mis = mi;
        tbl.push_back(v);
    endfunction

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_epc,
                           input logic em, input logic fu, input logic ov, input logic un,
                           input logic mi);
        chk({tag, " pc"},    pc,                 e_pc);
        chk({tag, " epc"},   epc,                e_epc);
        chk({tag, " empty"}, {31'd0, ras_empty}, {31'd0, em});
        chk({tag, " full"},  {31'd0, ras_full},  {31'd0, fu});
        chk({tag, " ovf"},   {31'd0, ras_ovf},   {31'd0, ov});
        chk({tag, " unf"},   {31'd0, ras_unf},   {31'd0, un});
        chk({tag, " mis"},   {31'd0, misalign},  {31'd0, mi});
    endtask

    initial begin
        rst_n = 1'b0;
        w = 1'b0; sel = SEQ; tgt = 32'd0; call = 1'b0; exc = 1'b0;
        w8 = 1'b0; sel8 = SEQ; tgt8 = 8'd0; call8 = 1'b0; exc8 = 1'b0;

        //   w     sel  target        call  exc   pc            epc           emp   full  ovf   unf   mis
        add(1'b1, SEQ, 32'h0,        1'b0, 1'b0, 32'h4,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, SEQ, 32'h0,        1'b0, 1'b0, 32'h8,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, SEQ, 32'h0,        1'b0, 1'b0, 32'hC,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, BR,  32'h40,       1'b0, 1'b0, 32'h40,       32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            add(1'b0, JMP, 32'h999,  1'b1, 1'b0, 32'h40,       32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, BR,  32'h10,       1'b0, 1'b0, 32'h10,       32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, JMP, 32'h100,      1'b1, 1'b0, 32'h100,      32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, RET, 32'h555,      1'b0, 1'b0, 32'h14,       32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, BR,  32'hA0,       1'b0, 1'b0, 32'hA0,       32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, JMP, 32'hB0,       1'b1, 1'b0, 32'hB0,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, JMP, 32'hC0,       1'b1, 1'b0, 32'hC0,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, JMP, 32'hD0,       1'b1, 1'b0, 32'hD0,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, JMP, 32'hE0,       1'b1, 1'b0, 32'hE0,       32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, JMP, 32'hF0,       1'b1, 1'b0, 32'hF0,       32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b1, RET, 32'h0,        1'b0, 1'b0, 32'hE4,       32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, RET, 32'h0,        1'b0, 1'b0, 32'hD4,       32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, RET, 32'h0,        1'b0, 1'b0, 32'hC4,       32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, RET, 32'h0,        1'b0, 1'b0, 32'hB4,       32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, RET, 32'h200,      1'b0, 1'b0, 32'h200,      32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b1, SEQ, 32'h0,        1'b0, 1'b0, 32'h204,      32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, BR,  32'h24,       1'b0, 1'b0, 32'h24,       32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, JMP, 32'h300,      1'b1, 1'b1, 32'h80,       32'h24,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, JMP, 32'h120,      1'b1, 1'b0, 32'h120,      32'h24,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, RET, 32'h444,      1'b1, 1'b0, 32'h84,       32'h24,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, RET, 32'h0,        1'b0, 1'b0, 32'h124,      32'h24,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, RET, 32'h180,      1'b1, 1'b0, 32'h180,      32'h24,       1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b1, RET, 32'h0,        1'b0, 1'b0, 32'h128,      32'h24,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, SEQ, 32'h0,        1'b0, 1'b1, 32'h80,       32'h128,      1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, BR,  32'h30,       1'b0, 1'b0, 32'h30,       32'h128,      1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef PC_ALIGN_CHK_EN
        add(1'b1, JMP, 32'h102,      1'b1, 1'b0, 32'h80,       32'h30,       1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b1, SEQ, 32'h0,        1'b0, 1'b0, 32'h84,       32'h30,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`else
        add(1'b1, JMP, 32'h102,      1'b0, 1'b0, 32'h102,      32'h128,      1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, SEQ, 32'h0,        1'b0, 1'b0, 32'h106,      32'h128,      1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset pc8", {24'd0, pc8}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            w = tbl[i].w; sel = tbl[i].sel; tgt = tbl[i].tgt;
            call = tbl[i].call; exc = tbl[i].exc;
            @(posedge clk);
            #1;
            chk_all($sformatf("row%0d", i), tbl[i].e_pc, tbl[i].e_epc, tbl[i].e_empty,
                    tbl[i].e_full, tbl[i].e_ovf, tbl[i].e_unf, tbl[i].e_mis);
        end

        // Asynchronous reset in the middle of a cycle clears state at once
        @(negedge clk);
        w = 1'b1; sel = SEQ; call = 1'b0; exc = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst", 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 8-bit instance: jump to 0xFC, one sequential step wraps to 0x00
        @(negedge clk);
        w = 1'b0;
        w8 = 1'b1; sel8 = JMP; tgt8 = 8'hFC;
        @(posedge clk);
        #1;
        chk("w8 jump pc", {24'd0, pc8}, 32'hFC);
        @(negedge clk);
        sel8 = SEQ;
        @(posedge clk);
        #1;
        chk("w8 wrap pc", {24'd0, pc8}, 32'h00);
        chk("w8 wrap empty", {31'd0, empty8}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
